// File: rtl/pipe_decode_stage.sv
// Decode stage of the MIPS-subset pipeline: register file, decode, forwarding,
// load-use/RAW interlocks, branch/jump resolution and the ID/EX register.
module pipe_decode_stage #(
  parameter int DW     = 32,
  parameter bit FWD_EN = 1'b1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          if_valid,
  input  logic [31:0]   inst,
  input  logic [DW-1:0] dpc4,
  input  logic [DW-1:0] ealu,
  input  logic          mwreg,
  input  logic          mm2reg,
  input  logic [4:0]    mrn,
  input  logic [DW-1:0] malu,
  input  logic [DW-1:0] mmo,
  input  logic          wwreg,
  input  logic [4:0]    wrn,
  input  logic [DW-1:0] wdi,
  output logic          wpcir,
  output logic [1:0]    pcsource,
  output logic [DW-1:0] bpc,
  output logic [DW-1:0] jpc,
  output logic [DW-1:0] rpc,
  output logic          flush,
  output logic          evalid,
  output logic          ewreg,
  output logic          em2reg,
  output logic          ewmem,
  output logic          ealuimm,
  output logic          eshift,
  output logic          ejal,
  output logic          eillegal,
  output logic [3:0]    ealuc,
  output logic [4:0]    ern,
  output logic [DW-1:0] ea,
  output logic [DW-1:0] eb,
  output logic [DW-1:0] eimm,
  output logic [DW-1:0] epc4
);

  typedef struct packed {
    logic          valid;
    logic          wreg;
    logic          m2reg;
    logic          wmem;
    logic          aluimm;
    logic          shift;
    logic          jal;
    logic          illegal;
    logic [3:0]    aluc;
    logic [4:0]    rn;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] imm;
    logic [DW-1:0] pc4;
  } idex_t;

  logic [5:0] op, func;
  logic [4:0] rs, rt, rd, sa;
  assign op   = inst[31:26];
  assign rs   = inst[25:21];
  assign rt   = inst[20:16];
  assign rd   = inst[15:11];
  assign sa   = inst[10:6];
  assign func = inst[5:0];

  logic dWreg, dM2reg, dWmem, dAluimm, dShift, dJal, dJr, dJ, dBeq, dBne, dIllegal;
  logic useRs, useRt, immZext;
  logic [3:0] dAluc;
  logic [4:0] dRn;

  always_comb begin
    dWreg = 1'b0; dM2reg = 1'b0; dWmem = 1'b0; dAluimm = 1'b0; dShift = 1'b0;
    dJal = 1'b0; dJr = 1'b0; dJ = 1'b0; dBeq = 1'b0; dBne = 1'b0; dIllegal = 1'b0;
    useRs = 1'b0; useRt = 1'b0; immZext = 1'b0;
    dAluc = 4'b0000; dRn = 5'd0;
    case (op)
      6'b000000: begin
        dRn = rd;
        case (func)
          6'b100000: begin dWreg = 1'b1; useRs = 1'b1; useRt = 1'b1; dAluc = 4'b0000; end
          6'b100010: begin dWreg = 1'b1; useRs = 1'b1; useRt = 1'b1; dAluc = 4'b0100; end
          6'b100100: begin dWreg = 1'b1; useRs = 1'b1; useRt = 1'b1; dAluc = 4'b0001; end
          6'b100101: begin dWreg = 1'b1; useRs = 1'b1; useRt = 1'b1; dAluc = 4'b0101; end
          6'b100110: begin dWreg = 1'b1; useRs = 1'b1; useRt = 1'b1; dAluc = 4'b0010; end
          6'b000000: begin dWreg = 1'b1; useRt = 1'b1; dShift = 1'b1; dAluc = 4'b0011; end
          6'b000010: begin dWreg = 1'b1; useRt = 1'b1; dShift = 1'b1; dAluc = 4'b0111; end
          6'b000011: begin dWreg = 1'b1; useRt = 1'b1; dShift = 1'b1; dAluc = 4'b1111; end
          6'b001000: begin useRs = 1'b1; dJr = 1'b1; end
          default:   begin dIllegal = 1'b1; dRn = 5'd0; end
        endcase
      end
      6'b001000: begin dWreg = 1'b1; dAluimm = 1'b1; useRs = 1'b1; dRn = rt; end
      6'b001100: begin dWreg = 1'b1; dAluimm = 1'b1; useRs = 1'b1; dRn = rt; immZext = 1'b1; dAluc = 4'b0001; end
      6'b001101: begin dWreg = 1'b1; dAluimm = 1'b1; useRs = 1'b1; dRn = rt; immZext = 1'b1; dAluc = 4'b0101; end
      6'b001110: begin dWreg = 1'b1; dAluimm = 1'b1; useRs = 1'b1; dRn = rt; immZext = 1'b1; dAluc = 4'b0010; end
      6'b001111: begin dWreg = 1'b1; dAluimm = 1'b1; dRn = rt; immZext = 1'b1; dAluc = 4'b0110; end
      6'b100011: begin dWreg = 1'b1; dM2reg = 1'b1; dAluimm = 1'b1; useRs = 1'b1; dRn = rt; end
      6'b101011: begin dWmem = 1'b1; dAluimm = 1'b1; useRs = 1'b1; useRt = 1'b1; dRn = rt; end
      6'b000100: begin dBeq = 1'b1; useRs = 1'b1; useRt = 1'b1; dRn = rt; end
      6'b000101: begin dBne = 1'b1; useRs = 1'b1; useRt = 1'b1; dRn = rt; end
      6'b000010: dJ = 1'b1;
      6'b000011: begin dJal = 1'b1; dWreg = 1'b1; dRn = 5'd31; end
      default:   dIllegal = 1'b1;
    endcase
  end

  logic [DW-1:0] simm, zimm, dImm;
  assign simm = {{(DW-16){inst[15]}}, inst[15:0]};
  assign zimm = {{(DW-16){1'b0}}, inst[15:0]};
  assign dImm = dShift ? {{(DW-5){1'b0}}, sa} : (immZext ? zimm : simm);

  logic [DW-1:0] regs_q [32];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (wwreg && wrn != 5'd0) begin
      regs_q[wrn] <= wdi;
    end
  end

  // Read ports see this cycle's WB write so WB never needs its own forward path.
  logic [DW-1:0] rfA, rfB;
  assign rfA = (rs == 5'd0) ? '0 : ((wwreg && wrn == rs) ? wdi : regs_q[rs]);
  assign rfB = (rt == 5'd0) ? '0 : ((wwreg && wrn == rt) ? wdi : regs_q[rt]);

  idex_t idex_d, idex_q;

  logic exHitA, exHitB, memHitA, memHitB;
  logic [DW-1:0] memVal, da, db;
  assign memVal  = mm2reg ? mmo : malu;
  assign exHitA  = FWD_EN && rs != 5'd0 && idex_q.wreg && !idex_q.m2reg && idex_q.rn == rs;
  assign exHitB  = FWD_EN && rt != 5'd0 && idex_q.wreg && !idex_q.m2reg && idex_q.rn == rt;
  assign memHitA = FWD_EN && rs != 5'd0 && mwreg && mrn == rs;
  assign memHitB = FWD_EN && rt != 5'd0 && mwreg && mrn == rt;
  assign da = exHitA ? ealu : (memHitA ? memVal : rfA);
  assign db = exHitB ? ealu : (memHitB ? memVal : rfB);

  function automatic logic srcHazard(input logic [4:0] s, input logic ew, input logic em2,
                                     input logic [4:0] eDst, input logic mw, input logic [4:0] mDst);
    srcHazard = (s != 5'd0) &&
                ((ew && em2 && eDst == s) ||
                 (!FWD_EN && ((ew && eDst == s) || (mw && mDst == s))));
  endfunction

  logic stall, issue, taken;
  assign stall = if_valid &&
                 ((useRs && srcHazard(rs, idex_q.wreg, idex_q.m2reg, idex_q.rn, mwreg, mrn)) ||
                  (useRt && srcHazard(rt, idex_q.wreg, idex_q.m2reg, idex_q.rn, mwreg, mrn)));
  assign issue = if_valid && !stall;
  assign taken = (dBeq && da == db) || (dBne && da != db);

  always_comb begin
    pcsource = 2'b00;
    if (issue) begin
      if (taken)             pcsource = 2'b01;
      else if (dJr)          pcsource = 2'b10;
      else if (dJ || dJal)   pcsource = 2'b11;
    end
  end

  assign wpcir = !stall;
  assign flush = (pcsource != 2'b00);
  assign bpc   = dpc4 + {simm[DW-3:0], 2'b00};
  assign jpc   = {dpc4[DW-1:28], inst[25:0], 2'b00};
  assign rpc   = da;

  // Stalls and empty IF/ID slots both turn into an all-zero bubble.
  always_comb begin
    idex_d = '0;
    if (issue) begin
      idex_d.valid   = 1'b1;
      idex_d.wreg    = dWreg && (dRn != 5'd0);
      idex_d.m2reg   = dM2reg;
      idex_d.wmem    = dWmem;
      idex_d.aluimm  = dAluimm;
      idex_d.shift   = dShift;
      idex_d.jal     = dJal;
      idex_d.illegal = dIllegal;
      idex_d.aluc    = dAluc;
      idex_d.rn      = dRn;
      idex_d.a       = da;
      idex_d.b       = db;
      idex_d.imm     = dImm;
      idex_d.pc4     = dpc4;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) idex_q <= '0;
    else       idex_q <= idex_d;
  end

  assign evalid   = idex_q.valid;
  assign ewreg    = idex_q.wreg;
  assign em2reg   = idex_q.m2reg;
  assign ewmem    = idex_q.wmem;
  assign ealuimm  = idex_q.aluimm;
  assign eshift   = idex_q.shift;
  assign ejal     = idex_q.jal;
  assign eillegal = idex_q.illegal;
  assign ealuc    = idex_q.aluc;
  assign ern      = idex_q.rn;
  assign ea       = idex_q.a;
  assign eb       = idex_q.b;
  assign eimm     = idex_q.imm;
  assign epc4     = idex_q.pc4;

endmodule

// File: doc/pipe_decode_stage.md
# pipe_decode_stage

Parametrised decode stage for the 5-stage MIPS-subset pipeline. It contains the register file, instruction decode, operand forwarding, load-use and RAW interlocks, and branch/jump resolution. It also owns the registered ID/EX pipeline register. It sits between the IF/ID register and the execute stage, and its registered outputs feed back into its own hazard logic.

## Interface
Parameters:
- DW, 32: datapath width (32 or 64); PC and register width.
- FWD_EN, 1: 1 = forward from EX/MEM; 0 = stall on every EX/MEM RAW hazard.

Ports:
- clock  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- if_valid  in  1  IF/ID holds a real instruction; 0 = decode as bubble.
- inst  in  32  instruction in ID.
- dpc4  in  DW  PC+4 of instruction in ID.
- ealu  in  DW  EX-stage ALU result (current cycle).
- mwreg, mm2reg  in  1 each  MEM write-enable / load flag.
- mrn  in  5  MEM destination.
- malu, mmo  in  DW each  MEM ALU result / load data.
- wwreg  in  1  WB write-enable.
- wrn  in  5  WB destination.
- wdi  in  DW  WB data.
- wpcir  out  1  0 = hold PC and IF/ID (stall); combinational.
- pcsource  out  2  00 pc4, 01 branch, 10 jr, 11 j/jal; combinational.
- bpc, jpc, rpc  out  DW each  branch, jump and jr targets; combinational.
- flush  out  1  squash IF/ID next edge (taken control transfer); combinational.
- evalid, ewreg, em2reg, ewmem, ealuimm, eshift, ejal, eillegal  out  1 each  registered ID/EX controls.
- ealuc  out  4  registered ALU op.
- ern  out  5  registered destination.
- ea, eb, eimm, epc4  out  DW each  registered operands, immediate and link PC.

## Operation
- Supported: R add/sub/and/or/xor/sll/srl/sra/jr; I addi/andi/ori/xori/lui/lw/sw/beq/bne; J j/jal. Any other op/func decodes as NOP with eillegal=1 (only when if_valid).
- ealuc: add 0000, sub 0100, and 0001, or 0101, xor 0010, lui 0110, sll 0011, srl 0111, sra 1111. addi/lw/sw use add; beq/bne/j/jr carry 0000.
- Sign-extend imm16 to DW for addi/lw/sw/beq/bne; zero-extend for andi/ori/xori/lui. For shifts, eimm = zero-extended inst[10:6] and eshift=1.
- Destination: rd for R-type, rt for I-type, 31 for jal. ewreg=0 when destination is 0.
- Source use: rs by R-type non-shift, jr, I-arith, lw, sw, beq, bne. rt by R-type (incl. shifts), sw, beq, bne.
- Register file: 32×DW, r0 reads 0. Write on edge when wwreg & wrn≠0. A same-cycle read of wrn returns wdi (internal bypass). Reset clears all entries.
- Forwarding (FWD_EN=1), per used source s≠0, highest priority first:
  - EX: ewreg & ~em2reg & ern==s gives ealu.
  - MEM: mwreg & mrn==s gives mm2reg ? mmo : malu.
  - Otherwise the register file (with bypass).
- Stall conditions:
  - Load-use: ewreg & em2reg & ern==s, any FWD_EN.
  - FWD_EN=0 only: ewreg & ern==s, or mwreg & mrn==s.
- Stall response: wpcir=0, pcsource=00, flush=0. The ID/EX register loads a bubble (all enables 0, evalid=0, eillegal=0).
- Branch/jump resolution uses the forwarded da/db:
  - beq taken iff da==db; bne taken iff da≠db.
  - bpc = dpc4 + (simm<<2), modulo 2^DW.
  - jpc = {dpc4[DW-1:28], inst[25:0], 00}.
  - rpc = da.
  - A taken branch, j, jal or jr drives the matching pcsource and flush=1. There is no delay slot.
- jal: epc4 = dpc4 (EX writes the link from epc4 when ejal).
- if_valid=0: bubble into ID/EX, no stall, no flush.

## Timing
- Decode, forwarding, hazard and branch outputs are combinational in the same cycle.
- ID/EX updates every rising edge; it is never held.
- Latency from inst to ID/EX outputs: 1 cycle.
- Load-use stall lasts exactly 1 cycle with FWD_EN=1. With FWD_EN=0, stall lasts until the producer leaves MEM (up to 2 cycles).
- Reset (synchronous, any cycle, including mid-stall): the next edge zeroes every ID/EX output and the register file. Combinational outputs follow from the zeroed state.
- Simultaneous stall and taken branch: stall wins. The branch resolves in the first non-stalled cycle using refreshed operands.
- Simultaneous EX/MEM/WB match: the EX result is used.

## Test plan
- Reset: assert reset 1 cycle → all e* outputs 0 and reading r5 gives 0; write r5=0x1234 via WB, then addi r6,r5,1 → ea=0x1234, eimm=1.
- EX forward: add r3,r1,r2 then sub r4,r3,r1 with ealu=0x10 → ea=0x10, wpcir=1. With FWD_EN=0, wpcir=0 for 2 cycles.
- Load-use: lw r7,0(r1) then add r8,r7,r7 → wpcir=0 for 1 cycle, bubble with evalid=0; next cycle ea=eb=mmo.
- Branch: beq r1,r2,-1 with r1=r2=5, dpc4=0x100 → pcsource=01, bpc=0xFC, flush=1. bne with the same operands → pcsource=00.
- jal target 0x40 at dpc4=0x80000010 → jpc=0x80000100, ern=31, epc4=0x80000010. jr r31 → pcsource=10, rpc equals forwarded r31.
- Illegal op 0x3F with if_valid=1 → eillegal=1, ewreg=ewmem=0. Same op with if_valid=0 → eillegal=0.
